cdc_pulse_pacer: RTL and testbench

//  clk_fast-domain stage directly upstream of the fast->slow pulse CDC handshake.

---
 rtl/cdc_pulse_pacer_if.sv | 28 ++
 rtl/cdc_pulse_pacer.sv | 111 +++++++++++
 tb/tb_cdc_pulse_pacer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_pulse_pacer_if.sv
// Signal bundle for cdc_pulse_pacer: event/control inputs and paced-pulse/status outputs.
// evt_i is a one-cycle strobe with no ready: every high cycle is one event, accepted or dropped.
interface cdc_pulse_pacer_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 8
);
   logic             enable_i;
   logic             evt_i;
   logic [GAP_W-1:0] gap_i;
   logic             flush_i;
   logic             clr_i;
   logic             pulse_o;
   logic [CNT_W-1:0] pending_o;
   logic             busy_o;
   logic             overflow_o;
   logic [CNT_W-1:0] drop_cnt_o;
   logic [1:0]       state_o;

   modport master (
      output enable_i, evt_i, gap_i, flush_i, clr_i,
      input  pulse_o, pending_o, busy_o, overflow_o, drop_cnt_o, state_o
   );

   modport slave (
      input  enable_i, evt_i, gap_i, flush_i, clr_i,
      output pulse_o, pending_o, busy_o, overflow_o, drop_cnt_o, state_o
   );
endinterface

// File: rtl/cdc_pulse_pacer.sv
// Counts fast event strobes and re-issues them as single-cycle pulses spaced at least
// max(gap_i,1)+1 cycles apart, so the downstream pulse CDC never sees two pulses in flight.
module cdc_pulse_pacer #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 8
) (
   input logic              clk_fast,
   input logic              resetn_i,
   cdc_pulse_pacer_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FIRE = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] pending_q;
   logic [CNT_W-1:0] drop_cnt_q;
   logic             overflow_q;
   logic             pulse_q;
   logic [GAP_W-1:0] hold_q;

   logic             enter_fire;
   logic             can_fire;
   logic             evt_in;
   logic             drop;

   assign can_fire = (pending_q != '0) && bus.enable_i;

   always_comb begin
      state_d    = state_q;
      enter_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_fire) begin
               state_d    = FIRE;
               enter_fire = 1'b1;
            end
         end
         FIRE: state_d = HOLD;
         HOLD: begin
            if (hold_q == '0) begin
               if (can_fire) begin
                  state_d    = FIRE;
                  enter_fire = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A flush discards the same-cycle event; a simultaneous fire decrement cancels the increment.
   assign evt_in = bus.evt_i && !bus.flush_i;
   assign drop   = evt_in && (&pending_q) && !enter_fire;

   always_ff @(posedge clk_fast or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
         pulse_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pulse_q <= enter_fire;
         if (enter_fire) begin
            hold_q <= (bus.gap_i == '0) ? '0 : bus.gap_i - GAP_ONE;
         end else if (state_q == HOLD && hold_q != '0) begin
            hold_q <= hold_q - GAP_ONE;
         end
      end
   end

   always_ff @(posedge clk_fast or negedge resetn_i) begin
      if (!resetn_i) begin
         pending_q <= '0;
      end else if (bus.flush_i) begin
         pending_q <= '0;
      end else if (evt_in && !enter_fire && !(&pending_q)) begin
         pending_q <= pending_q + CNT_ONE;
      end else if (enter_fire && !evt_in) begin
         pending_q <= pending_q - CNT_ONE;
      end
   end

   // A drop on the same edge as a clear leaves the record of that drop.
   always_ff @(posedge clk_fast or negedge resetn_i) begin
      if (!resetn_i) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (bus.clr_i) begin
         overflow_q <= drop;
         drop_cnt_q <= drop ? CNT_ONE : '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (!(&drop_cnt_q)) begin
            drop_cnt_q <= drop_cnt_q + CNT_ONE;
         end
      end
   end

   assign bus.pulse_o    = pulse_q;
   assign bus.pending_o  = pending_q;
   assign bus.busy_o     = (state_q != IDLE);
   assign bus.overflow_o = overflow_q;
   assign bus.drop_cnt_o = drop_cnt_q;
   assign bus.state_o    = state_q;
endmodule

// File: tb/tb_cdc_pulse_pacer.sv
// Self-checking bench for cdc_pulse_pacer: expected pulse cycles are queued per scenario and
// matched as pulses appear; a second CNT_W=2 instance covers backlog saturation.
module tb_cdc_pulse_pacer;
   logic clk_fast = 1'b0;
   logic resetn_i;

   always #5 clk_fast = ~clk_fast;

   cdc_pulse_pacer_if #(.CNT_W(8), .GAP_W(8)) bus ();
   cdc_pulse_pacer_if #(.CNT_W(2), .GAP_W(8)) sbus ();

   cdc_pulse_pacer #(.CNT_W(8), .GAP_W(8)) dut (
      .clk_fast (clk_fast),
      .resetn_i (resetn_i),
      .bus      (bus.slave)
   );

   cdc_pulse_pacer #(.CNT_W(2), .GAP_W(8)) sat (
      .clk_fast (clk_fast),
      .resetn_i (resetn_i),
      .bus      (sbus.slave)
   );

   int unsigned cyc = 0;
   int unsigned t0 = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk_fast) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_fast);
      #1;
   endtask

   task automatic start_test(input logic [7:0] gap);
      bus.gap_i = gap;
      step();
      t0 = cyc;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy_o && bus.pending_o == 0) break;
         step();
      end
      check({tag, "_idle"}, {31'd0, bus.busy_o} | 32'(bus.pending_o), 0);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   // Scoreboard: every pulse must match the oldest queued cycle of the running scenario.
   always @(negedge clk_fast) begin
      if (resetn_i && bus.pulse_o) begin
         if (exp_q.size() == 0) check("unexpected_pulse", cyc - t0, 32'hFFFF_FFFF);
         else check("pulse_cycle", cyc - t0, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned peak;
      int unsigned npulse;

      resetn_i      = 1'b0;
      bus.enable_i  = 1'b1;
      bus.evt_i     = 1'b0;
      bus.gap_i     = 8'd3;
      bus.flush_i   = 1'b0;
      bus.clr_i     = 1'b0;
      sbus.enable_i = 1'b0;
      sbus.evt_i    = 1'b0;
      sbus.gap_i    = 8'd3;
      sbus.flush_i  = 1'b0;
      sbus.clr_i    = 1'b0;
      step(3);
      check("rst_pulse", bus.pulse_o, 0);
      check("rst_pending", bus.pending_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_ovf", bus.overflow_o, 0);
      check("rst_drop", bus.drop_cnt_o, 0);
      check("rst_state", bus.state_o, 0);
      check("rst_sat_pending", sat_pending(), 0);
      resetn_i = 1'b1;
      step(2);
      check("post_rst_busy", bus.busy_o, 0);

      // T1: single event, gap 3
      start_test(8'd3);
      exp_q.push_back(2);
      bus.evt_i = 1'b1;
      step();
      bus.evt_i = 1'b0;
      check("t1_pend_c1", bus.pending_o, 1);
      check("t1_busy_c1", bus.busy_o, 0);
      for (int c = 2; c <= 6; c++) begin
         step();
         if (c == 2) check("t1_pend_c2", bus.pending_o, 0);
         check("t1_busy", bus.busy_o, (c <= 5) ? 1 : 0);
      end
      wait_idle("t1");

      // T2: burst of 5, gap 3
      start_test(8'd3);
      for (int k = 0; k < 5; k++) exp_q.push_back(2 + 4 * k);
      bus.evt_i = 1'b1;
      peak = 0;
      for (int c = 1; c <= 22; c++) begin
         step();
         if (c == 5) bus.evt_i = 1'b0;
         if (bus.pending_o > peak) peak = bus.pending_o;
      end
      check("t2_peak", peak, 4);
      check("t2_drop", bus.drop_cnt_o, 0);
      check("t2_ovf", bus.overflow_o, 0);
      wait_idle("t2");

      // T3: gap 0 behaves as 1
      start_test(8'd0);
      exp_q.push_back(2);
      exp_q.push_back(4);
      exp_q.push_back(6);
      bus.evt_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 3) bus.evt_i = 1'b0;
      end
      wait_idle("t3");

      // T4: saturation on the CNT_W=2 instance
      sbus.enable_i = 1'b0;
      sbus.evt_i = 1'b1;
      step(6);
      sbus.evt_i = 1'b0;
      step();
      check("t4_pending", sat_pending(), 3);
      check("t4_ovf", sbus.overflow_o, 1);
      check("t4_drop", sbus.drop_cnt_o, 3);
      sbus.clr_i = 1'b1;
      step();
      sbus.clr_i = 1'b0;
      check("t4_clr_ovf", sbus.overflow_o, 0);
      check("t4_clr_drop", sbus.drop_cnt_o, 0);
      check("t4_clr_pending", sat_pending(), 3);
      sbus.enable_i = 1'b1;
      npulse = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (sbus.pulse_o) npulse++;
      end
      check("t4_pulses", npulse, 3);
      check("t4_end_pending", sat_pending(), 0);
      check("t4_end_busy", sbus.busy_o, 0);

      // T5: same-edge event/fire, then flush during HOLD
      start_test(8'd5);
      exp_q.push_back(2);
      bus.evt_i = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 2) check("t5_simul_pend", bus.pending_o, 1);
         if (c == 5) begin
            check("t5_pend_before_flush", bus.pending_o, 4);
            bus.flush_i = 1'b1;
         end
         if (c == 6) begin
            bus.flush_i = 1'b0;
            bus.evt_i = 1'b0;
            check("t5_flushed", bus.pending_o, 0);
            check("t5_hold_busy", bus.busy_o, 1);
         end
         if (c == 7) check("t5_hold_last", bus.busy_o, 1);
         if (c == 8) check("t5_idle", bus.busy_o, 0);
      end
      check("t5_drop", bus.drop_cnt_o, 0);
      wait_idle("t5");

      // T6: reset during FIRE
      start_test(8'd3);
      bus.evt_i = 1'b1;
      step();
      bus.evt_i = 1'b0;
      step();
      check("t6_fire_pulse", bus.pulse_o, 1);
      #1 resetn_i = 1'b0;
      #1;
      check("t6_rst_pulse", bus.pulse_o, 0);
      check("t6_rst_busy", bus.busy_o, 0);
      check("t6_rst_pending", bus.pending_o, 0);
      step(2);
      resetn_i = 1'b1;
      step(8);
      check("t6_after_busy", bus.busy_o, 0);
      check("t6_after_pending", bus.pending_o, 0);
      start_test(8'd3);
      exp_q.push_back(2);
      bus.evt_i = 1'b1;
      step();
      bus.evt_i = 1'b0;
      step(6);
      wait_idle("t6_new");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   function automatic logic [31:0] sat_pending();
      return 32'(sbus.pending_o);
   endfunction
endmodule
